// File: rtl/pic_pkg.sv
// Shared types and priority helpers for the PIC service controller.
package pic_pkg;

  typedef logic [2:0] pic_level_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACK1,
    ACK2
  } pic_state_t;

  localparam int         NUM_IRQ    = 8;
  localparam pic_level_t LOWEST_RST = 3'd7;

  // Rank 0 is the highest priority, counted from the level after lowest.
  function automatic pic_level_t prio_rank(
    input pic_level_t level,
    input pic_level_t lowest
  );
    return level - lowest - 3'd1;
  endfunction

  // Returns {found, level}; scans lowest priority first so the last hit wins.
  function automatic logic [3:0] rot_highest(
    input logic [7:0] bits,
    input pic_level_t lowest
  );
    logic [3:0] r;
    pic_level_t idx;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = lowest + 3'(i) + 3'd1;
      if (bits[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_service_controller_prio_enc.sv
// Combinational rotating priority encoder.
module pic_rot_prio_enc
  import pic_pkg::*;
(
  input  logic [7:0] bits,
  input  pic_level_t lowest,
  output logic       found,
  output pic_level_t level
);

  logic [3:0] hit;

  assign hit   = rot_highest(bits, lowest);
  assign found = hit[3];
  assign level = hit[2:0];

endmodule

// File: rtl/pic_service_controller.sv
// 8259-style interrupt service sequencer: INT, two-pulse INTA, ISR, EOI.
// Optional automatic EOI is enabled by defining PIC_AEOI_EN.
module pic_service_controller
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irr,
  input  logic       inta_n,
  input  logic [4:0] vec_base,
  input  logic       rotate_en,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  pic_level_t eoi_level,
`ifdef PIC_AEOI_EN
  input  logic       aeoi,
`endif
  output logic       int_out,
  output logic [7:0] irr_clr,
  output logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  pic_state_t state, state_n;
  pic_level_t lowest, lowest_n;
  pic_level_t lvl, lvl_n;
  pic_level_t eff_lowest;
  pic_level_t best, isr_top;
  logic       spur, spur_n;
  logic       inta_q;
  logic       fall, rise;
  logic       irr_found, isr_found;
  logic       eligible;
  logic       aeoi_on;
  logic       int_n, doe_n;
  logic [7:0] clr_n, isr_n, dout_n;

`ifdef PIC_AEOI_EN
  assign aeoi_on = aeoi;
`else
  assign aeoi_on = 1'b0;
`endif

  assign fall       = inta_q & ~inta_n;
  assign rise       = ~inta_q & inta_n;
  assign eff_lowest = rotate_en ? lowest : 3'd7;

  pic_rot_prio_enc u_irr_enc (
    .bits   (irr),
    .lowest (eff_lowest),
    .found  (irr_found),
    .level  (best)
  );

  pic_rot_prio_enc u_isr_enc (
    .bits   (isr),
    .lowest (eff_lowest),
    .found  (isr_found),
    .level  (isr_top)
  );

  // Fully nested: only strictly higher-ranked requests may interrupt.
  assign eligible = irr_found &&
    (!isr_found ||
     prio_rank(best, eff_lowest) < prio_rank(isr_top, eff_lowest));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      inta_q   <= 1'b1;
      int_out  <= 1'b0;
      irr_clr  <= '0;
      isr      <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      lowest   <= LOWEST_RST;
      lvl      <= '0;
      spur     <= 1'b0;
    end else begin
      state    <= state_n;
      inta_q   <= inta_n;
      int_out  <= int_n;
      irr_clr  <= clr_n;
      isr      <= isr_n;
      data_out <= dout_n;
      data_oe  <= doe_n;
      lowest   <= lowest_n;
      lvl      <= lvl_n;
      spur     <= spur_n;
    end
  end

  always_comb begin
    state_n  = state;
    int_n    = int_out;
    clr_n    = '0;
    isr_n    = isr;
    dout_n   = data_out;
    doe_n    = data_oe;
    lowest_n = lowest;
    lvl_n    = lvl;
    spur_n   = spur;
    unique case (state)
      IDLE: begin
        if (eligible) begin
          int_n   = 1'b1;
          state_n = PEND;
        end
      end
      PEND: begin
        if (fall) begin
          if (eligible) begin
            lvl_n        = best;
            isr_n[best]  = 1'b1;
            clr_n[best]  = 1'b1;
            spur_n       = 1'b0;
          end else begin
            lvl_n  = 3'd7;
            spur_n = 1'b1;
          end
          int_n   = 1'b0;
          state_n = ACK1;
        end
      end
      ACK1: begin
        if (rise) state_n = ACK2;
      end
      ACK2: begin
        if (fall) begin
          dout_n = {vec_base, lvl};
          doe_n  = 1'b1;
        end else if (rise) begin
          doe_n   = 1'b0;
          state_n = IDLE;
          if (aeoi_on && !spur) begin
            isr_n[lvl] = 1'b0;
            if (rotate_en) lowest_n = lvl;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // EOI lands after any ISR set of the same cycle.
    if (eoi_valid) begin
      if (eoi_specific) begin
        isr_n[eoi_level] = 1'b0;
      end else if (isr_found) begin
        isr_n[isr_top] = 1'b0;
        if (rotate_en) lowest_n = isr_top;
      end
    end
  end

endmodule
